// File: rtl/imp_excite_seq.sv
// rtl/imp_excite_seq.sv - measurement sequencer for the impedance excitation DAC controller
// Phase-aligns the DAC, runs settle periods, then measure periods that gate the demodulator window.
module imp_excite_seq #(
   parameter int PCNT_W = 8
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              Start,
   input  logic              Abort,
   input  logic              CfgStepNum,
   input  logic [PCNT_W-1:0] CfgSettle,
   input  logic [PCNT_W-1:0] CfgMeas,
   output logic              DacResetn,
   output logic              CountEnable,
   output logic              StepNum,
   output logic              IntegClear,
   output logic              IntegEnable,
   output logic              Busy,
   output logic              Done,
   output logic              Aborted,
   output logic [PCNT_W-1:0] PeriodCnt
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ALIGN,
      ST_SETTLE,
      ST_MEASURE,
      ST_FINISH
   } state_t;

   state_t            state, state_n;
   logic [4:0]        phase, phase_n;
   logic [PCNT_W-1:0] settle_q, settle_n;
   logic [PCNT_W-1:0] meas_q, meas_n;
   logic [PCNT_W-1:0] pcnt_n;
   logic              step_n;
   logic              aborted_n;
   logic              boundary;
   logic              last_settle;
   logic              last_meas;

   logic              dac_resetn_n;
   logic              count_enable_n;
   logic              integ_clear_n;
   logic              integ_enable_n;
   logic              busy_n;
   logic              done_n;

   // Period boundary tracks the latched step mode, not the live config input.
   assign boundary    = (phase == (StepNum ? 5'd15 : 5'd31));
   assign last_settle = (PeriodCnt == (settle_q - PCNT_W'(1)));
   assign last_meas   = (PeriodCnt == (meas_q - PCNT_W'(1)));

   always_comb begin
      state_n   = state;
      phase_n   = phase;
      pcnt_n    = PeriodCnt;
      step_n    = StepNum;
      settle_n  = settle_q;
      meas_n    = meas_q;
      aborted_n = 1'b0;

      case (state)
         ST_IDLE: begin
            if (Start && !Abort) begin
               step_n   = CfgStepNum;
               settle_n = CfgSettle;
               meas_n   = (CfgMeas == '0) ? PCNT_W'(1) : CfgMeas;
               pcnt_n   = '0;
               state_n  = ST_ALIGN;
            end
         end

         ST_ALIGN: begin
            if (Abort) begin
               aborted_n = 1'b1;
               state_n   = ST_IDLE;
            end else begin
               phase_n = '0;
               pcnt_n  = '0;
               state_n = (settle_q != '0) ? ST_SETTLE : ST_MEASURE;
            end
         end

         ST_SETTLE: begin
            if (Abort) begin
               aborted_n = 1'b1;
               state_n   = ST_IDLE;
            end else if (boundary) begin
               phase_n = '0;
               if (last_settle) begin
                  pcnt_n  = '0;
                  state_n = ST_MEASURE;
               end else begin
                  pcnt_n = PeriodCnt + PCNT_W'(1);
               end
            end else begin
               phase_n = phase + 5'd1;
            end
         end

         ST_MEASURE: begin
            if (Abort) begin
               aborted_n = 1'b1;
               state_n   = ST_IDLE;
            end else if (boundary) begin
               phase_n = '0;
               if (last_meas) begin
                  state_n = ST_FINISH;
               end else begin
                  pcnt_n = PeriodCnt + PCNT_W'(1);
               end
            end else begin
               phase_n = phase + 5'd1;
            end
         end

         ST_FINISH: begin
            state_n = ST_IDLE;
         end

         default: begin
            state_n = ST_IDLE;
         end
      endcase

      // Outputs are decoded from the next state so every output is a flop.
      dac_resetn_n   = (state_n != ST_ALIGN);
      integ_clear_n  = (state_n == ST_ALIGN);
      count_enable_n = (state_n == ST_SETTLE) || (state_n == ST_MEASURE);
      integ_enable_n = (state_n == ST_MEASURE);
      busy_n         = (state_n != ST_IDLE);
      done_n         = (state_n == ST_FINISH);
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state       <= ST_IDLE;
         phase       <= '0;
         settle_q    <= '0;
         meas_q      <= '0;
         DacResetn   <= 1'b0;
         CountEnable <= 1'b0;
         StepNum     <= 1'b0;
         IntegClear  <= 1'b0;
         IntegEnable <= 1'b0;
         Busy        <= 1'b0;
         Done        <= 1'b0;
         Aborted     <= 1'b0;
         PeriodCnt   <= '0;
      end else begin
         state       <= state_n;
         phase       <= phase_n;
         settle_q    <= settle_n;
         meas_q      <= meas_n;
         DacResetn   <= dac_resetn_n;
         CountEnable <= count_enable_n;
         StepNum     <= step_n;
         IntegClear  <= integ_clear_n;
         IntegEnable <= integ_enable_n;
         Busy        <= busy_n;
         Done        <= done_n;
         Aborted     <= aborted_n;
         PeriodCnt   <= pcnt_n;
      end
   end

endmodule

// File: tb/tb_imp_excite_seq.sv
// tb/tb_imp_excite_seq.sv - scoreboard bench for imp_excite_seq
// Stimulus pushes per-run expectations; the monitor pops on each Done/Aborted pulse.
module tb_imp_excite_seq;

   logic       Clk = 1'b0;
   logic       Reset = 1'b1;
   logic       Start = 1'b0;
   logic       Abort = 1'b0;
   logic       CfgStepNum = 1'b0;
   logic [7:0] CfgSettle = 8'd0;
   logic [7:0] CfgMeas = 8'd0;
   logic       DacResetn, CountEnable, StepNum, IntegClear, IntegEnable;
   logic       Busy, Done, Aborted;
   logic [7:0] PeriodCnt;

   imp_excite_seq #(.PCNT_W(8)) dut (
      .Clk(Clk), .Reset(Reset), .Start(Start), .Abort(Abort),
      .CfgStepNum(CfgStepNum), .CfgSettle(CfgSettle), .CfgMeas(CfgMeas),
      .DacResetn(DacResetn), .CountEnable(CountEnable), .StepNum(StepNum),
      .IntegClear(IntegClear), .IntegEnable(IntegEnable), .Busy(Busy),
      .Done(Done), .Aborted(Aborted), .PeriodCnt(PeriodCnt)
   );

   always #5 Clk = ~Clk;

   typedef struct {
      int busy, ce, ie, clr, rstlow, ce_first, ie_first, done, aborted, pcnt, step;
   } exp_t;

   exp_t q[$];
   exp_t e;
   int   checks = 0;
   int   failures = 0;
   int   m_busy, m_ce, m_ie, m_clr, m_rstlow, m_ce_first, m_ie_first;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   task automatic push_exp(input int busy, input int ce, input int ie, input int ce_first,
                           input int ie_first, input int done, input int aborted,
                           input int pcnt, input int step);
      exp_t x;
      x.busy = busy; x.ce = ce; x.ie = ie; x.clr = 1; x.rstlow = 1;
      x.ce_first = ce_first; x.ie_first = ie_first; x.done = done;
      x.aborted = aborted; x.pcnt = pcnt; x.step = step;
      q.push_back(x);
   endtask

   task automatic clear_mon();
      m_busy = 0; m_ce = 0; m_ie = 0; m_clr = 0; m_rstlow = 0;
      m_ce_first = -1; m_ie_first = -1;
   endtask

   always @(negedge Clk) begin
      if (Reset) begin
         clear_mon();
      end else begin
         if (Busy) begin
            if (CountEnable && m_ce_first < 0) m_ce_first = m_busy;
            if (IntegEnable && m_ie_first < 0) m_ie_first = m_busy;
            m_ce     += int'(CountEnable);
            m_ie     += int'(IntegEnable);
            m_clr    += int'(IntegClear);
            m_rstlow += int'(!DacResetn);
            m_busy++;
         end
         if (Done || Aborted) begin
            if (q.size() == 0) begin
               chk("unexpected_pulse", 1, 0);
            end else begin
               e = q.pop_front();
               chk("busy_cycles", m_busy, e.busy);
               chk("ce_cycles", m_ce, e.ce);
               chk("ie_cycles", m_ie, e.ie);
               chk("clear_cycles", m_clr, e.clr);
               chk("dacrst_cycles", m_rstlow, e.rstlow);
               chk("ce_first", m_ce_first, e.ce_first);
               chk("ie_first", m_ie_first, e.ie_first);
               chk("done", int'(Done), e.done);
               chk("aborted", int'(Aborted), e.aborted);
               chk("period_cnt", int'(PeriodCnt), e.pcnt);
               chk("step_num", int'(StepNum), e.step);
               chk("ce_at_pulse", int'(CountEnable), 0);
               chk("ie_at_pulse", int'(IntegEnable), 0);
            end
            clear_mon();
         end
      end
   end

   task automatic check_reset_vals();
      chk("rst_dacresetn", int'(DacResetn), 0);
      chk("rst_ce", int'(CountEnable), 0);
      chk("rst_step", int'(StepNum), 0);
      chk("rst_clear", int'(IntegClear), 0);
      chk("rst_ie", int'(IntegEnable), 0);
      chk("rst_busy", int'(Busy), 0);
      chk("rst_done", int'(Done), 0);
      chk("rst_aborted", int'(Aborted), 0);
      chk("rst_pcnt", int'(PeriodCnt), 0);
   endtask

   task automatic set_cfg(input logic step, input int settle, input int meas);
      CfgStepNum = step;
      CfgSettle  = 8'(settle);
      CfgMeas    = 8'(meas);
   endtask

   task automatic start_run();
      @(posedge Clk); #1 Start = 1'b1;
      @(posedge Clk); #1 Start = 1'b0;
   endtask

   task automatic wait_idle();
      bit idle = 0;
      for (int i = 0; i < 400; i++) begin
         @(negedge Clk);
         if (!Busy) begin
            idle = 1;
            break;
         end
      end
      chk("idle_timeout", int'(idle), 1);
      repeat (2) @(posedge Clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      clear_mon();
      repeat (3) begin
         @(negedge Clk);
         check_reset_vals();
      end
      @(posedge Clk); #1 Reset = 1'b0;
      @(posedge Clk);
      @(negedge Clk);
      chk("post_rst_dacresetn", int'(DacResetn), 1);
      chk("post_rst_busy", int'(Busy), 0);

      // Start and Abort together in IDLE: nothing starts.
      set_cfg(1'b0, 2, 3);
      @(posedge Clk); #1 Start = 1'b1; Abort = 1'b1;
      @(posedge Clk); #1 Start = 1'b0; Abort = 1'b0;
      @(negedge Clk);
      chk("start_abort_busy", int'(Busy), 0);
      chk("start_abort_aborted", int'(Aborted), 0);

      // 32-step, settle 2, measure 3
      set_cfg(1'b0, 2, 3);
      push_exp(162, 160, 96, 1, 65, 1, 0, 2, 0);
      start_run();
      wait_idle();

      // 16-step, settle skipped, measure 0 treated as 1
      set_cfg(1'b1, 0, 0);
      push_exp(18, 16, 16, 1, 1, 1, 0, 0, 1);
      start_run();
      wait_idle();

      // Abort on MEASURE cycle 40
      set_cfg(1'b0, 2, 3);
      push_exp(105, 104, 40, 1, 65, 0, 1, 1, 0);
      start_run();
      repeat (104) @(posedge Clk);
      #1 Abort = 1'b1;
      @(posedge Clk); #1 Abort = 1'b0;
      wait_idle();

      // Abort during ALIGN
      push_exp(1, 0, 0, -1, -1, 0, 1, 0, 0);
      start_run();
      Abort = 1'b1;
      @(posedge Clk); #1 Abort = 1'b0;
      wait_idle();

      // Start re-pulsed and config changed mid-run
      set_cfg(1'b0, 2, 3);
      push_exp(162, 160, 96, 1, 65, 1, 0, 2, 0);
      start_run();
      repeat (20) @(posedge Clk);
      #1 Start = 1'b1; set_cfg(1'b1, 0, 1);
      @(posedge Clk); #1 Start = 1'b0;
      repeat (80) @(posedge Clk);
      #1 Start = 1'b1;
      @(posedge Clk); #1 Start = 1'b0;
      wait_idle();

      // Abort during FINISH is ignored
      set_cfg(1'b1, 0, 1);
      push_exp(18, 16, 16, 1, 1, 1, 0, 0, 1);
      start_run();
      begin
         bit seen = 0;
         for (int i = 0; i < 100; i++) begin
            @(negedge Clk);
            if (Done) begin
               seen = 1;
               break;
            end
         end
         chk("done_seen", int'(seen), 1);
      end
      Abort = 1'b1;
      @(negedge Clk);
      chk("abort_in_finish", int'(Aborted), 0);
      Abort = 1'b0;
      wait_idle();

      // Reset during SETTLE, then a normal run
      set_cfg(1'b0, 2, 3);
      start_run();
      repeat (10) @(posedge Clk);
      #1 Reset = 1'b1;
      @(posedge Clk);
      @(negedge Clk);
      check_reset_vals();
      @(posedge Clk); #1 Reset = 1'b0;
      @(posedge Clk);
      @(negedge Clk);
      chk("rerun_dacresetn", int'(DacResetn), 1);
      chk("rerun_busy", int'(Busy), 0);
      set_cfg(1'b1, 1, 1);
      push_exp(34, 32, 16, 1, 17, 1, 0, 0, 1);
      start_run();
      wait_idle();

      repeat (3) @(posedge Clk);
      chk("queue_empty", q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
